// File: rtl/hba_arbiter_if.sv
// hba_arbiter_if
//   Bundles the per-master request and transfer fields with the shared HBA
//   slave bus that the arbiter drives.
//   Packed master fields: master i lives at [i*WIDTH +: WIDTH].
//   Signals:
//     master_request [NUM_MASTERS]           per-master bus request
//     master_abus    [NUM_MASTERS*ADDR_WIDTH] per-master address
//     master_rnw     [NUM_MASTERS]           per-master 1=read, 0=write
//     master_select  [NUM_MASTERS]           per-master transfer in progress
//     master_dbus    [NUM_MASTERS*DBUS_WIDTH] per-master write data
//     hba_mgrant     [NUM_MASTERS]           one-hot registered grant
//     hba_abus/hba_rnw/hba_select/hba_dbus   granted master's fields, 0 when idle
//   Modports:
//     master : the bus-master side (drives requests, observes grant and bus)
//     slave  : the arbiter side (consumes requests, drives grant and bus)
interface hba_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int DBUS_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12
);
  logic [NUM_MASTERS-1:0]            master_request;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_abus;
  logic [NUM_MASTERS-1:0]            master_rnw;
  logic [NUM_MASTERS-1:0]            master_select;
  logic [NUM_MASTERS*DBUS_WIDTH-1:0] master_dbus;

  logic [NUM_MASTERS-1:0]            hba_mgrant;
  logic [ADDR_WIDTH-1:0]             hba_abus;
  logic                              hba_rnw;
  logic                              hba_select;
  logic [DBUS_WIDTH-1:0]             hba_dbus;

  modport master (
    output master_request, master_abus, master_rnw, master_select, master_dbus,
    input  hba_mgrant, hba_abus, hba_rnw, hba_select, hba_dbus
  );

  modport slave (
    input  master_request, master_abus, master_rnw, master_select, master_dbus,
    output hba_mgrant, hba_abus, hba_rnw, hba_select, hba_dbus
  );
endinterface

// File: rtl/hba_arbiter.sv
// hba_arbiter
//   Round-robin arbiter between NUM_MASTERS HBA bus masters and the shared
//   HBA slave bus. Grants one master at a time, holds the grant while the
//   owner still requests or has a transfer in flight, and always inserts one
//   idle HANDOVER cycle after a release. The granted master's address, rnw,
//   select and write data are AND-OR muxed onto the bus by the registered grant.
//   Ports:
//     hba_clk    in  bus clock, all state on the rising edge
//     hba_reset  in  asynchronous active-low reset
//     bus        hba_arbiter_if.slave: master fields in, grant and bus out
module hba_arbiter #(
  parameter int NUM_MASTERS       = 2,
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH
) (
  input  logic          hba_clk,
  input  logic          hba_reset,
  hba_arbiter_if.slave  bus
);

  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    HANDOVER = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [OW-1:0]          last_owner_reg, last_owner_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;

  logic [OW-1:0]          winner;
  logic [OW-1:0]          scan_idx;
  logic                   any_request;
  logic                   owner_busy;

  // State register. last_owner resets to the top index so master 0 is the
  // first one the rotating scan reaches.
  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      state_reg      <= IDLE;
      last_owner_reg <= OW'(NUM_MASTERS - 1);
      grant_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      grant_reg      <= grant_next;
    end
  end

  // Rotating priority scan starting just after the previous owner; the
  // previous owner itself is checked last, so it cannot win back-to-back
  // while anybody else is requesting.
  always_comb begin
    winner      = last_owner_reg;
    any_request = 1'b0;
    scan_idx    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      scan_idx = OW'((int'(last_owner_reg) + k) % NUM_MASTERS);
      if (!any_request && bus.master_request[scan_idx]) begin
        any_request = 1'b1;
        winner      = scan_idx;
      end
    end
  end

  // The owner keeps the bus while it still asks for it or a transfer is open.
  assign owner_busy = bus.master_request[last_owner_reg] | bus.master_select[last_owner_reg];

  // Next-state logic.
  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    grant_next      = grant_reg;
    case (state_reg)
      IDLE, HANDOVER: begin
        grant_next = '0;
        if (any_request) begin
          state_next         = GRANT;
          grant_next[winner] = 1'b1;
          last_owner_next    = winner;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT: begin
        if (!owner_busy) begin
          state_next = HANDOVER;
          grant_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // Output logic: per-master fields masked by the registered grant, then
  // OR-ed together. Since the grant is one-hot or zero, this is a mux that
  // yields all-zero outputs when nobody owns the bus.
  logic [ADDR_WIDTH-1:0] abus_masked [NUM_MASTERS];
  logic [DBUS_WIDTH-1:0] dbus_masked [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] rnw_masked;
  logic [NUM_MASTERS-1:0] select_masked;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mask
    assign abus_masked[gi]   = {ADDR_WIDTH{grant_reg[gi]}} & bus.master_abus[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign dbus_masked[gi]   = {DBUS_WIDTH{grant_reg[gi]}} & bus.master_dbus[gi*DBUS_WIDTH +: DBUS_WIDTH];
    assign rnw_masked[gi]    = grant_reg[gi] & bus.master_rnw[gi];
    assign select_masked[gi] = grant_reg[gi] & bus.master_select[gi];
  end

  always_comb begin
    bus.hba_abus = '0;
    bus.hba_dbus = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bus.hba_abus = bus.hba_abus | abus_masked[i];
      bus.hba_dbus = bus.hba_dbus | dbus_masked[i];
    end
  end

  assign bus.hba_rnw    = |rnw_masked;
  assign bus.hba_select = |select_masked;
  assign bus.hba_mgrant = grant_reg;

endmodule

// File: tb/tb_hba_arbiter.sv
// tb_hba_arbiter
//   Directed bench for hba_arbiter with two masters, 12-bit address and
//   8-bit data. Inputs change 1 time unit after a rising edge; registered
//   and combinational outputs are checked after that.
module tb_hba_arbiter;

  localparam int NM = 2;
  localparam int DW = 8;
  localparam int AW = 12;

  logic hba_clk;
  logic hba_reset;

  int checks   = 0;
  int failures = 0;

  hba_arbiter_if #(.NUM_MASTERS(NM), .DBUS_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  hba_arbiter #(
    .NUM_MASTERS(NM),
    .DBUS_WIDTH(DW),
    .PERIPH_ADDR_WIDTH(4),
    .REG_ADDR_WIDTH(8)
  ) dut (
    .hba_clk  (hba_clk),
    .hba_reset(hba_reset),
    .bus      (bus_if)
  );

  initial hba_clk = 1'b0;
  always #5 hba_clk = ~hba_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge hba_clk);
    #1;
  endtask

  task automatic drive(input logic [NM-1:0] req, input logic [NM-1:0] sel,
                       input logic [NM-1:0] rnw, input logic [NM*AW-1:0] abus,
                       input logic [NM*DW-1:0] dbus);
    bus_if.master_request = req;
    bus_if.master_select  = sel;
    bus_if.master_rnw     = rnw;
    bus_if.master_abus    = abus;
    bus_if.master_dbus    = dbus;
  endtask

  task automatic check_bus_zero(input string tag);
    check_eq({tag, "_grant"},  32'(bus_if.hba_mgrant), 32'h0);
    check_eq({tag, "_abus"},   32'(bus_if.hba_abus),   32'h0);
    check_eq({tag, "_dbus"},   32'(bus_if.hba_dbus),   32'h0);
    check_eq({tag, "_select"}, 32'(bus_if.hba_select), 32'h0);
    check_eq({tag, "_rnw"},    32'(bus_if.hba_rnw),    32'h0);
  endtask

  // Contention sequence: request vector applied before each edge and the
  // grant expected after it. Master 0 starts (fresh reset), every release
  // is followed by an empty grant cycle, owners alternate.
  logic [NM-1:0] cont_req   [9] = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00};
  logic [NM-1:0] cont_grant [9] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};

  initial begin
    hba_reset = 1'b1;
    drive(2'b11, 2'b11, 2'b11, 24'h345678, 16'h9ABC);
    #1 hba_reset = 1'b0;
    #1 hba_reset = 1'b1;

    // Reset: a live grant must vanish mid-cycle, with no clock edge.
    tick();
    check_eq("pre_reset_grant", 32'(bus_if.hba_mgrant), 32'h1);
    #2 hba_reset = 1'b0;
    #1;
    check_bus_zero("async_reset");
    for (int i = 0; i < 3; i++) begin
      drive(2'($urandom), 2'($urandom), 2'($urandom), 24'($urandom), 16'($urandom));
      tick();
      check_eq("reset_hold_grant",  32'(bus_if.hba_mgrant), 32'h0);
      check_eq("reset_hold_select", 32'(bus_if.hba_select), 32'h0);
      check_eq("reset_hold_abus",   32'(bus_if.hba_abus),   32'h0);
    end
    drive(2'b00, 2'b00, 2'b00, 24'h0, 16'h0);
    #2 hba_reset = 1'b1;
    tick();
    check_eq("idle_no_req_grant", 32'(bus_if.hba_mgrant), 32'h0);

    // Single grant to master 0.
    drive(2'b01, 2'b01, 2'b01, {12'h000, 12'h012}, {8'h00, 8'h5A});
    tick();
    check_eq("single_grant",  32'(bus_if.hba_mgrant), 32'h1);
    check_eq("single_abus",   32'(bus_if.hba_abus),   32'h012);
    check_eq("single_select", 32'(bus_if.hba_select), 32'h1);
    check_eq("single_rnw",    32'(bus_if.hba_rnw),    32'h1);
    check_eq("single_dbus",   32'(bus_if.hba_dbus),   32'h5A);
    drive(2'b00, 2'b00, 2'b00, 24'h0, 16'h0);
    tick();
    check_eq("single_release", 32'(bus_if.hba_mgrant), 32'h0);
    tick();
    check_bus_zero("single_idle");

    // Isolation: master 1 drives loud values without a request.
    drive(2'b01, 2'b11, 2'b10, {12'hFFF, 12'h345}, {8'hAA, 8'h11});
    tick();
    check_eq("iso_grant",  32'(bus_if.hba_mgrant), 32'h1);
    check_eq("iso_abus",   32'(bus_if.hba_abus),   32'h345);
    check_eq("iso_dbus",   32'(bus_if.hba_dbus),   32'h11);
    check_eq("iso_rnw",    32'(bus_if.hba_rnw),    32'h0);
    check_eq("iso_select", 32'(bus_if.hba_select), 32'h1);
    drive(2'b00, 2'b00, 2'b00, 24'h0, 16'h0);
    tick();
    check_eq("iso_release", 32'(bus_if.hba_mgrant), 32'h0);
    tick();

    // Select hold: request drops, select stays up for three cycles.
    drive(2'b01, 2'b01, 2'b00, {12'h000, 12'h0A5}, 16'h0);
    tick();
    check_eq("hold_grant", 32'(bus_if.hba_mgrant), 32'h1);
    drive(2'b00, 2'b01, 2'b00, {12'h000, 12'h0A5}, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_select_grant", 32'(bus_if.hba_mgrant), 32'h1);
    end
    check_eq("hold_abus", 32'(bus_if.hba_abus), 32'h0A5);
    drive(2'b00, 2'b00, 2'b00, 24'h0, 16'h0);
    tick();
    check_eq("hold_release", 32'(bus_if.hba_mgrant), 32'h0);
    tick();

    // Contention from a fresh reset.
    #1 hba_reset = 1'b0;
    #1 hba_reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus_if.master_request = cont_req[i];
      tick();
      check_eq($sformatf("contend_%0d_grant", i), 32'(bus_if.hba_mgrant), 32'(cont_grant[i]));
    end

    // Reset in the middle of a master 1 transfer.
    drive(2'b10, 2'b10, 2'b00, {12'h7C3, 12'h111}, {8'h3C, 8'h00});
    tick();
    check_eq("m1_grant",  32'(bus_if.hba_mgrant), 32'h2);
    check_eq("m1_abus",   32'(bus_if.hba_abus),   32'h7C3);
    check_eq("m1_select", 32'(bus_if.hba_select), 32'h1);
    check_eq("m1_dbus",   32'(bus_if.hba_dbus),   32'h3C);
    #2 hba_reset = 1'b0;
    #1;
    check_bus_zero("midgrant_reset");
    drive(2'b11, 2'b00, 2'b00, {12'h7C3, 12'h111}, 16'h0);
    #2 hba_reset = 1'b1;
    tick();
    check_eq("after_reset_grant", 32'(bus_if.hba_mgrant), 32'h1);
    check_eq("after_reset_abus",  32'(bus_if.hba_abus),   32'h111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
